text_writer: RTL and testbench
==============================

# text_writer

Upstream feeder for the text-mode VGA renderer. Takes a stream of ASCII codes from the keyboard decoder, tracks a terminal cursor on the 70×30 character grid, and writes character codes into the video memory that the renderer scans. Handles printable characters, newline, backspace and line wrap. It clears the whole screen after reset and clears each row as the cursor enters it.

## Interface
- COLS, 70, characters per row
- ROWS, 30, rows per screen
- FILL, 8'h20, code written when clearing a cell
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- ascii_in  in  8  character code from upstream
- valid_in  in  1  ascii_in is valid
- ready_out  out  1  block can accept a character this cycle
- vmem_we  out  1  video memory write enable, one-cycle pulse per write
- vmem_waddr  out  12  write address, row*COLS+col
- vmem_wdata  out  8  write data
- cursor_row  out  5  current cursor row, 0..ROWS-1
- cursor_col  out  7  current cursor column, 0..COLS-1
- busy  out  1  a clear sweep is in progress

## Operation
- States:
  - INIT_CLR: full-screen clear, ROWS*COLS writes.
  - IDLE: accepting characters.
  - LINE_CLR: clears one row, COLS writes.
- Reset state is INIT_CLR. Every output is 0 during reset.
- ready_out = (state==IDLE). busy = (state!=IDLE).
- Transfer occurs on a posedge with valid_in && ready_out. In IDLE, at most one character is accepted per cycle.
- Printable, 0x20..0x7E:
  - Write the code at (row,col).
  - Then col+1.
  - If col was COLS-1: col=0, row=(row+1) mod ROWS, go to LINE_CLR for the new row.
- 0x0D or 0x0A:
  - No write.
  - col=0, row=(row+1) mod ROWS, go to LINE_CLR.
- 0x08 backspace:
  - If col>0: col-1, write FILL at the new position.
  - If col==0 and row>0: row-1, col=COLS-1, write FILL there.
  - At (0,0): no-op, no write.
- Any other code is accepted and dropped: no write, cursor unchanged.
- Address arithmetic: row*70 computed as (row<<6)+(row<<2)+(row<<1), 12-bit unsigned. The maximum address is 2099.
- Clear sweeps:
  - A 12-bit counter steps the address by 1 and writes FILL each cycle.
  - INIT_CLR covers 0..ROWS*COLS-1.
  - LINE_CLR covers row*COLS..row*COLS+COLS-1.
- Wrap from row ROWS-1 goes to row 0. Row 0 is then cleared, so there is no scrolling.
- Reset asserted mid-sweep or mid-write:
  - Immediate return to INIT_CLR with cursor (0,0).
  - Pending write is dropped.
  - Full clear restarts after reset release.

## Timing
- Write outputs are registered. A character accepted at edge N appears as vmem_we=1 with addr/data during cycle N+1, i.e. set at edge N and cleared at edge N+1 unless another write follows.
- Cursor outputs update at the accept edge N.
- INIT_CLR:
  - Starts at the first posedge after reset release.
  - Address 0 is presented after that edge, then one address per cycle.
  - The edge that issues address 2099 also moves the state to IDLE, so ready_out=1 in the same cycle the last clear write is on the port.
  - Total 2100 cycles of ready_out=0.
- LINE_CLR:
  - The accept edge sets state=LINE_CLR.
  - The next COLS edges issue the COLS writes.
  - The edge issuing the last write returns the state to IDLE.
  - ready_out is low for exactly COLS cycles after the accept.
- vmem_we is high every cycle of a sweep, a back-to-back write stream. The vmem write port accepts one write per cycle with no backpressure.
- valid_in held while ready_out=0 is not consumed. The upstream holds ascii_in stable until the transfer occurs.

## Configuration
- TEXT_WRITER_TAB_EN defined: 0x09 advances col to the next multiple of 8, with no write.
  - If the target column is ≥COLS, it is treated as newline: col=0, row+1, LINE_CLR.
- TEXT_WRITER_TAB_EN undefined: 0x09 is accepted and dropped like any other non-printable code.

## Test plan
- Release reset → exactly 2100 consecutive writes of 0x20 on addresses 0..2099. ready_out rises in the cycle carrying address 2099. Cursor reads (0,0).
- In IDLE, send 'A' (0x41) then 'B' → writes (0,0x41) and (1,0x42) on consecutive cycles. Cursor ends at (0,2).
- Send 0x0D at (0,2) → cursor (1,0). Then 70 writes of 0x20 to addresses 70..139 with ready_out low for 70 cycles.
- With cursor at (1,0), send 0x08 → write 0x20 at address 69, cursor (0,69). Send 0x08 at (0,0) → no write, cursor unchanged.
- Fill to (29,69) and send 'Z' → write 0x5A at address 2099. Cursor (0,0). Row 0 cleared at addresses 0..69.
- Assert reset during a LINE_CLR sweep → all outputs 0 immediately. Full 2100-write clear follows release.
- With TEXT_WRITER_TAB_EN defined, 0x09 at col 3 → col 8, no write. Without it, cursor stays at col 3.

Source files
------------

// File: rtl/text_writer.sv
// Terminal-style writer: tracks a cursor on the 70x30 text grid and writes codes into video memory.
// Optional feature: define TEXT_WRITER_TAB_EN to make 0x09 advance to the next 8-column tab stop.
module text_writer #(
  parameter int         COLS = 70,
  parameter int         ROWS = 30,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ascii_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        vmem_we,
  output logic [11:0] vmem_waddr,
  output logic [7:0]  vmem_wdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  typedef enum logic [1:0] {INIT_CLR, IDLE, LINE_CLR} state_t;

  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [11:0] CLR_LAST = 12'(ROWS * COLS - 1);

  state_t      state, state_nxt;
  logic [4:0]  row, row_nxt, row_inc;
  logic [6:0]  col, col_nxt;
  logic [11:0] clr_addr, clr_addr_nxt, clr_end, clr_end_nxt;
  logic        we_nxt;
  logic [11:0] waddr_nxt;
  logic [7:0]  wdata_nxt;
  logic        accept, is_print, is_nl, is_bs, new_line;
  logic [11:0] row_base, inc_base;
`ifdef TEXT_WRITER_TAB_EN
  logic        is_tab;
  logic [6:0]  tab_col;
`endif

  // row*70 as shift-and-add so no multiplier is inferred
  function automatic logic [11:0] times_cols(input logic [4:0] r);
    logic [11:0] rx;
    rx = {7'd0, r};
    return (rx << 6) + (rx << 2) + (rx << 1);
  endfunction

  assign accept   = valid_in && (state == IDLE);
  assign row_inc  = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
  assign row_base = times_cols(row);
  assign inc_base = times_cols(row_inc);
  assign is_print = (ascii_in >= 8'h20) && (ascii_in <= 8'h7E);
  assign is_nl    = (ascii_in == 8'h0D) || (ascii_in == 8'h0A);
  assign is_bs    = (ascii_in == 8'h08);
`ifdef TEXT_WRITER_TAB_EN
  assign is_tab   = (ascii_in == 8'h09);
  assign tab_col  = {col[6:3], 3'b000} + 7'd8;
  assign new_line = (is_print && col == COL_LAST) || is_nl || (is_tab && tab_col >= 7'(COLS));
`else
  assign new_line = (is_print && col == COL_LAST) || is_nl;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT_CLR;
      row        <= 5'd0;
      col        <= 7'd0;
      clr_addr   <= 12'd0;
      clr_end    <= CLR_LAST;
      vmem_we    <= 1'b0;
      vmem_waddr <= 12'd0;
      vmem_wdata <= 8'd0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      clr_addr   <= clr_addr_nxt;
      clr_end    <= clr_end_nxt;
      vmem_we    <= we_nxt;
      vmem_waddr <= waddr_nxt;
      vmem_wdata <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_CLR, LINE_CLR: if (clr_addr == clr_end) state_nxt = IDLE;
      IDLE:               if (accept && new_line) state_nxt = LINE_CLR;
      default:            state_nxt = INIT_CLR;
    endcase
  end

  // Next cursor, sweep counter and registered write port
  always_comb begin
    row_nxt      = row;
    col_nxt      = col;
    clr_addr_nxt = clr_addr;
    clr_end_nxt  = clr_end;
    we_nxt       = 1'b0;
    waddr_nxt    = vmem_waddr;
    wdata_nxt    = vmem_wdata;
    if (state != IDLE) begin
      we_nxt       = 1'b1;
      waddr_nxt    = clr_addr;
      wdata_nxt    = FILL;
      clr_addr_nxt = clr_addr + 12'd1;
    end else if (accept) begin
      if (new_line) begin
        row_nxt      = row_inc;
        col_nxt      = 7'd0;
        clr_addr_nxt = inc_base;
        clr_end_nxt  = inc_base + 12'(COLS - 1);
      end
      if (is_print) begin
        we_nxt    = 1'b1;
        waddr_nxt = row_base + {5'd0, col};
        wdata_nxt = ascii_in;
        if (col != COL_LAST) col_nxt = col + 7'd1;
      end else if (is_bs) begin
        if (col != 7'd0) begin
          col_nxt   = col - 7'd1;
          we_nxt    = 1'b1;
          waddr_nxt = row_base + {5'd0, col - 7'd1};
          wdata_nxt = FILL;
        end else if (row != 5'd0) begin
          row_nxt   = row - 5'd1;
          col_nxt   = COL_LAST;
          we_nxt    = 1'b1;
          waddr_nxt = times_cols(row - 5'd1) + {5'd0, COL_LAST};
          wdata_nxt = FILL;
        end
      end
`ifdef TEXT_WRITER_TAB_EN
      else if (is_tab && !new_line) begin
        col_nxt = tab_col;
      end
`endif
    end
  end

  assign ready_out  = (state == IDLE) && !reset;
  assign busy       = (state != IDLE) && !reset;
  assign cursor_row = row;
  assign cursor_col = col;

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer: init clear, printing, newline, backspace, wrap, reset.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ascii_in = 8'd0;
  logic        valid_in = 1'b0;
  logic        ready_out, vmem_we, busy;
  logic [11:0] vmem_waddr;
  logic [7:0]  vmem_wdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  int checks = 0;
  int failures = 0;

  text_writer dut (
    .clk(clk), .reset(reset), .ascii_in(ascii_in), .valid_in(valid_in),
    .ready_out(ready_out), .vmem_we(vmem_we), .vmem_waddr(vmem_waddr),
    .vmem_wdata(vmem_wdata), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Follows a clear sweep from its first write sample; ready must rise only with the last write
  task automatic run_sweep(input int base, input int n, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (vmem_we !== 1'b1 || vmem_waddr !== 12'(base + k) || vmem_wdata !== 8'h20) bad++;
      if (ready_out !== ((k == n - 1) ? 1'b1 : 1'b0)) bad++;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_out !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ready_out !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL wait_ready: ready_out=%b required 1 within 3000 cycles", ready_out);
    end
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready();
    valid_in = 1'b1;
    ascii_in = c;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clk);
    checks++;
    if ({vmem_we, vmem_waddr, vmem_wdata, ready_out, busy, cursor_row, cursor_col} !== 35'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got we=%b addr=%0d data=%h rdy=%b busy=%b row=%0d col=%0d required all 0",
               vmem_we, vmem_waddr, vmem_wdata, ready_out, busy, cursor_row, cursor_col);
    end
    reset = 1'b0;
    run_sweep(0, 2100, bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL init_sweep: bad samples=%0d required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (vmem_we !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL init_done: we=%b rdy=%b busy=%b required 0 1 0", vmem_we, ready_out, busy);
    end
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      failures++;
      $display("[TB] FAIL init_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_print();
    valid_in = 1'b1;
    ascii_in = 8'h41;
    @(negedge clk);
    checks++;
    if (vmem_we !== 1'b1 || vmem_waddr !== 12'd0 || vmem_wdata !== 8'h41 || cursor_col !== 7'd1) begin
      failures++;
      $display("[TB] FAIL print_A: we=%b addr=%0d data=%h col=%0d required 1 0 41 1",
               vmem_we, vmem_waddr, vmem_wdata, cursor_col);
    end
    ascii_in = 8'h42;
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (vmem_we !== 1'b1 || vmem_waddr !== 12'd1 || vmem_wdata !== 8'h42 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd2) begin
      failures++;
      $display("[TB] FAIL print_B: we=%b addr=%0d data=%h cur=(%0d,%0d) required 1 1 42 (0,2)",
               vmem_we, vmem_waddr, vmem_wdata, cursor_row, cursor_col);
    end
    @(negedge clk);
    checks++;
    if (vmem_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL print_idle_we: got %b required 0", vmem_we);
    end
  endtask

  task automatic test_newline();
    int bad;
    send(8'h0D);
    checks++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0 || vmem_we !== 1'b0 || ready_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL newline_accept: cur=(%0d,%0d) we=%b rdy=%b busy=%b required (1,0) 0 0 1",
               cursor_row, cursor_col, vmem_we, ready_out, busy);
    end
    run_sweep(70, 70, bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL newline_sweep: bad samples=%0d required 0", bad);
    end
  endtask

  task automatic test_backspace();
    int bad = 0;
    send(8'h08);
    checks++;
    if (vmem_we !== 1'b1 || vmem_waddr !== 12'd69 || vmem_wdata !== 8'h20 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd69) begin
      failures++;
      $display("[TB] FAIL bs_row_up: we=%b addr=%0d data=%h cur=(%0d,%0d) required 1 69 20 (0,69)",
               vmem_we, vmem_waddr, vmem_wdata, cursor_row, cursor_col);
    end
    valid_in = 1'b1;
    ascii_in = 8'h08;
    for (int i = 0; i < 69; i++) begin
      @(negedge clk);
      if (vmem_we !== 1'b1 || vmem_waddr !== 12'(68 - i) || vmem_wdata !== 8'h20) bad++;
    end
    valid_in = 1'b0;
    checks++;
    if (bad !== 0 || cursor_col !== 7'd0) begin
      failures++;
      $display("[TB] FAIL bs_run: bad=%0d col=%0d required 0 0", bad, cursor_col);
    end
    send(8'h08);
    checks++;
    if (vmem_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      failures++;
      $display("[TB] FAIL bs_origin: we=%b cur=(%0d,%0d) required 0 (0,0)", vmem_we, cursor_row, cursor_col);
    end
  endtask

  task automatic test_drop_tab();
    logic [6:0] exp_col;
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h01);
    checks++;
    if (vmem_we !== 1'b0 || cursor_col !== 7'd3 || ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_ctrl: we=%b col=%0d rdy=%b required 0 3 1", vmem_we, cursor_col, ready_out);
    end
`ifdef TEXT_WRITER_TAB_EN
    exp_col = 7'd8;
`else
    exp_col = 7'd3;
`endif
    send(8'h09);
    checks++;
    if (vmem_we !== 1'b0 || cursor_col !== exp_col || cursor_row !== 5'd0) begin
      failures++;
      $display("[TB] FAIL tab: we=%b cur=(%0d,%0d) required 0 (0,%0d)", vmem_we, cursor_row, cursor_col, exp_col);
    end
  endtask

  task automatic test_wrap();
    int bad;
    for (int i = 0; i < 29; i++) send(8'h0A);
    wait_ready();
    checks++;
    if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin
      failures++;
      $display("[TB] FAIL wrap_setup: cur=(%0d,%0d) required (29,0)", cursor_row, cursor_col);
    end
    valid_in = 1'b1;
    ascii_in = 8'h71;
    repeat (69) @(negedge clk);
    ascii_in = 8'h5A;
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (vmem_we !== 1'b1 || vmem_waddr !== 12'd2099 || vmem_wdata !== 8'h5A ||
        cursor_row !== 5'd0 || cursor_col !== 7'd0 || ready_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_last: we=%b addr=%0d data=%h cur=(%0d,%0d) rdy=%b required 1 2099 5a (0,0) 0",
               vmem_we, vmem_waddr, vmem_wdata, cursor_row, cursor_col, ready_out);
    end
    run_sweep(0, 70, bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL wrap_row0_clear: bad samples=%0d required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    send(8'h0D);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({vmem_we, vmem_waddr, vmem_wdata, ready_out, busy, cursor_row, cursor_col} !== 35'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: we=%b addr=%0d data=%h rdy=%b busy=%b row=%0d col=%0d required all 0",
               vmem_we, vmem_waddr, vmem_wdata, ready_out, busy, cursor_row, cursor_col);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_sweep(0, 2100, bad);
    checks++;
    if (bad !== 0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_sweep: bad=%0d cur=(%0d,%0d) required 0 (0,0)", bad, cursor_row, cursor_col);
    end
  endtask

  initial begin
    $display("[TB] text_writer bench start");
    test_reset();
    test_print();
    test_newline();
    test_backspace();
    test_drop_tab();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
